// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store controller: access sizes,
// trap cause codes and FSM state encoding.
package mem_access_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_ILL  = 2'b11;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_ILL_SIZE = 2'b10;
   localparam logic [1:0] CAUSE_OOB      = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_e;

   // Bytes touched by an access; the illegal size reports 1 (it traps anyway).
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SIZE_BYTE: size_bytes = 3'd1;
         SIZE_HALF: size_bytes = 3'd2;
         SIZE_WORD: size_bytes = 3'd4;
         default:   size_bytes = 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/mem_align_check.sv
// Combinational request checker: size + address -> {trap, cause}.
// The bounds check is built only when MEM_BOUNDS_CHECK_EN is defined.
module mem_align_check
   import mem_access_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int MEM_BYTES = 256
) (
   input  logic [1:0]        size_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic              trap_o,
   output logic [1:0]        cause_o
);

`ifdef MEM_BOUNDS_CHECK_EN
   localparam logic BOUNDS_EN = 1'b1;
`else
   localparam logic BOUNDS_EN = 1'b0;
`endif

   logic [ADDR_W:0] last_s;
   logic            misalign_s;
   logic            oob_s;

   // One extra bit so an access that wraps past the top of the address space also traps.
   assign last_s = {1'b0, addr_i} + (ADDR_W+1)'(size_bytes(size_i)) - (ADDR_W+1)'(1);
   assign oob_s  = BOUNDS_EN & (last_s >= (ADDR_W+1)'(MEM_BYTES));

   // Alignment rule: halves on even addresses, words on multiples of four.
   always_comb begin
      misalign_s = 1'b0;
      case (size_i)
         SIZE_HALF: misalign_s = addr_i[0];
         SIZE_WORD: misalign_s = (addr_i[1:0] != 2'b00);
         default:   misalign_s = 1'b0;
      endcase
   end

   // Priority: illegal size, then misalignment, then bounds.
   always_comb begin
      trap_o  = 1'b0;
      cause_o = CAUSE_NONE;
      if (size_i == SIZE_ILL) begin
         trap_o  = 1'b1;
         cause_o = CAUSE_ILL_SIZE;
      end else if (misalign_s) begin
         trap_o  = 1'b1;
         cause_o = CAUSE_MISALIGN;
      end else if (oob_s) begin
         trap_o  = 1'b1;
         cause_o = CAUSE_OOB;
      end else begin
         trap_o  = 1'b0;
         cause_o = CAUSE_NONE;
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller in front of the byte-addressed data RAM.
// Optional bounds trap enabled by defining MEM_BOUNDS_CHECK_EN.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int MEM_BYTES = 256
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_sext_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [DATA_W-1:0] resp_rdata_o,
   output logic              resp_trap_o,
   output logic [1:0]        resp_cause_o,
   output logic              ram_en_o,
   output logic              ram_rw_o,
   output logic              ram_sext_o,
   output logic [1:0]        ram_size_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i
);

   state_e            state_q;
   logic              req_ready_q;
   logic              resp_valid_q;
   logic [DATA_W-1:0] resp_rdata_q;
   logic              resp_trap_q;
   logic [1:0]        resp_cause_q;
   logic              ram_en_q;
   logic              ram_rw_q;
   logic              ram_sext_q;
   logic [1:0]        ram_size_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [DATA_W-1:0] ram_wdata_q;
   logic              chk_trap_s;
   logic [1:0]        chk_cause_s;

   mem_align_check #(
      .ADDR_W    (ADDR_W),
      .MEM_BYTES (MEM_BYTES)
   ) u_align_check (
      .size_i  (req_size_i),
      .addr_i  (req_addr_i),
      .trap_o  (chk_trap_s),
      .cause_o (chk_cause_s)
   );

   // The ram_* registers double as the captured request; only ram_en gates the RAM.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_IDLE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= {DATA_W{1'b0}};
         resp_trap_q  <= 1'b0;
         resp_cause_q <= CAUSE_NONE;
         ram_en_q     <= 1'b0;
         ram_rw_q     <= 1'b0;
         ram_sext_q   <= 1'b0;
         ram_size_q   <= 2'b00;
         ram_addr_q   <= {ADDR_W{1'b0}};
         ram_wdata_q  <= {DATA_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid_i) begin
                  req_ready_q <= 1'b0;
                  ram_rw_q    <= req_write_i;
                  ram_sext_q  <= req_sext_i & ~req_write_i;
                  ram_size_q  <= req_size_i;
                  ram_addr_q  <= req_addr_i;
                  ram_wdata_q <= req_wdata_i;
                  if (chk_trap_s) begin
                     state_q      <= ST_RESP;
                     resp_valid_q <= 1'b1;
                     resp_trap_q  <= 1'b1;
                     resp_cause_q <= chk_cause_s;
                     resp_rdata_q <= {DATA_W{1'b0}};
                  end else begin
                     state_q  <= ST_ACCESS;
                     ram_en_q <= 1'b1;
                  end
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            ST_ACCESS: begin
               state_q      <= ST_RESP;
               ram_en_q     <= 1'b0;
               resp_valid_q <= 1'b1;
               resp_trap_q  <= 1'b0;
               resp_cause_q <= CAUSE_NONE;
               resp_rdata_q <= ram_rw_q ? {DATA_W{1'b0}} : ram_rdata_i;
            end
            ST_RESP: begin
               if (resp_ready_i) begin
                  state_q      <= ST_IDLE;
                  req_ready_q  <= 1'b1;
                  resp_valid_q <= 1'b0;
                  resp_trap_q  <= 1'b0;
                  resp_cause_q <= CAUSE_NONE;
                  resp_rdata_q <= {DATA_W{1'b0}};
               end else begin
                  state_q <= ST_RESP;
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               req_ready_q  <= 1'b1;
               resp_valid_q <= 1'b0;
               ram_en_q     <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready_o  = req_ready_q;
   assign resp_valid_o = resp_valid_q;
   assign resp_rdata_o = resp_rdata_q;
   assign resp_trap_o  = resp_trap_q;
   assign resp_cause_o = resp_cause_q;
   assign ram_en_o     = ram_en_q;
   assign ram_rw_o     = ram_rw_q;
   assign ram_sext_o   = ram_sext_q;
   assign ram_size_o   = ram_size_q;
   assign ram_addr_o   = ram_addr_q;
   assign ram_wdata_o  = ram_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Table-driven bench for mem_access_ctrl with a big-endian byte RAM model.
// The DUT is built with MEM_BYTES=128 so the bounds trap is visible when MEM_BOUNDS_CHECK_EN is defined.
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_sext;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_trap;
   logic [1:0]  resp_cause;
   logic        ram_en;
   logic        ram_rw;
   logic        ram_sext;
   logic [1:0]  ram_size;
   logic [7:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] mem [0:255];

   mem_access_ctrl #(
      .ADDR_W    (8),
      .DATA_W    (32),
      .MEM_BYTES (128)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_write_i  (req_write),
      .req_size_i   (req_size),
      .req_sext_i   (req_sext),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .resp_valid_o (resp_valid),
      .resp_ready_i (resp_ready),
      .resp_rdata_o (resp_rdata),
      .resp_trap_o  (resp_trap),
      .resp_cause_o (resp_cause),
      .ram_en_o     (ram_en),
      .ram_rw_o     (ram_rw),
      .ram_sext_o   (ram_sext),
      .ram_size_o   (ram_size),
      .ram_addr_o   (ram_addr),
      .ram_wdata_o  (ram_wdata),
      .ram_rdata_i  (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM read port: combinational, big-endian, extension done by the RAM.
   always_comb begin
      logic [7:0] a1, a2, a3;
      a1 = ram_addr + 8'd1;
      a2 = ram_addr + 8'd2;
      a3 = ram_addr + 8'd3;
      ram_rdata = 32'h0;
      if (ram_en && !ram_rw) begin
         case (ram_size)
            2'b00: ram_rdata = ram_sext ? {{24{mem[ram_addr][7]}}, mem[ram_addr]}
                                        : {24'h0, mem[ram_addr]};
            2'b01: ram_rdata = ram_sext ? {{16{mem[ram_addr][7]}}, mem[ram_addr], mem[a1]}
                                        : {16'h0, mem[ram_addr], mem[a1]};
            2'b10: ram_rdata = {mem[ram_addr], mem[a1], mem[a2], mem[a3]};
            default: ram_rdata = 32'h0;
         endcase
      end
   end

   // RAM write port.
   always @(posedge clk) begin
      if (ram_en && ram_rw) begin
         case (ram_size)
            2'b00: mem[ram_addr] <= ram_wdata[7:0];
            2'b01: begin
               mem[ram_addr]        <= ram_wdata[15:8];
               mem[ram_addr + 8'd1] <= ram_wdata[7:0];
            end
            2'b10: begin
               mem[ram_addr]        <= ram_wdata[31:24];
               mem[ram_addr + 8'd1] <= ram_wdata[23:16];
               mem[ram_addr + 8'd2] <= ram_wdata[15:8];
               mem[ram_addr + 8'd3] <= ram_wdata[7:0];
            end
            default: ;
         endcase
      end
   end

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        sext;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic        trap;
      logic [1:0]  cause;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sext,
                               input logic [7:0] addr, input logic [31:0] wdata,
                               input logic trap, input logic [1:0] cause, input logic [31:0] rdata);
      vec_t v;
      v.wr = wr; v.size = size; v.sext = sext; v.addr = addr; v.wdata = wdata;
      v.trap = trap; v.cause = cause; v.rdata = rdata;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic wr, input logic [1:0] size, input logic sext,
                            input logic [7:0] addr, input logic [31:0] wdata);
      req_valid = 1'b1;
      req_write = wr;
      req_size  = size;
      req_sext  = sext;
      req_addr  = addr;
      req_wdata = wdata;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int   lat;
      int   ens;
      logic c_rw, c_sext;
      logic [1:0] c_size;
      logic [7:0] c_addr;
      logic [31:0] c_wdata;
      c_rw = 1'b0; c_sext = 1'b0; c_size = 2'b00; c_addr = 8'h0; c_wdata = 32'h0;
      chk($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
      drive_req(v.wr, v.size, v.sext, v.addr, v.wdata);
      tick();
      req_valid = 1'b0;
      lat = 1;
      ens = 0;
      for (int c = 0; c < 8 && !resp_valid; c++) begin
         if (ram_en) begin
            ens++;
            c_rw = ram_rw; c_sext = ram_sext; c_size = ram_size;
            c_addr = ram_addr; c_wdata = ram_wdata;
         end
         tick();
         lat++;
      end
      if (ram_en) ens++;
      chk($sformatf("v%0d resp_valid", idx), 32'(resp_valid), 32'd1);
      chk($sformatf("v%0d latency", idx), 32'(lat), v.trap ? 32'd1 : 32'd2);
      chk($sformatf("v%0d ram_en_cycles", idx), 32'(ens), v.trap ? 32'd0 : 32'd1);
      chk($sformatf("v%0d trap", idx), 32'(resp_trap), 32'(v.trap));
      chk($sformatf("v%0d cause", idx), 32'(resp_cause), 32'(v.cause));
      chk($sformatf("v%0d rdata", idx), resp_rdata, v.rdata);
      if (!v.trap) begin
         chk($sformatf("v%0d ram_rw", idx), 32'(c_rw), 32'(v.wr));
         chk($sformatf("v%0d ram_size", idx), 32'(c_size), 32'(v.size));
         chk($sformatf("v%0d ram_addr", idx), 32'(c_addr), 32'(v.addr));
         chk($sformatf("v%0d ram_sext", idx), 32'(c_sext), 32'(v.sext & ~v.wr));
         if (v.wr) chk($sformatf("v%0d ram_wdata", idx), c_wdata, v.wdata);
      end
      tick();
      chk($sformatf("v%0d resp_drop", idx), 32'(resp_valid), 32'd0);
      chk($sformatf("v%0d back_idle", idx), 32'(req_ready), 32'd1);
   endtask

   initial begin
      int i1, i2, cyc;
      logic        seen;
      logic [31:0] hold_rdata;

      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_sext = 1'b0; req_addr = 8'h0; req_wdata = 32'h0; resp_ready = 1'b1;

      // Stores prime the RAM model; later loads read back through it.
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0, 2'b00, 32'h0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 1'b0, 2'b00, 32'hDEADBEEF));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 8'h13, 32'hAABBCCEF, 1'b0, 2'b00, 32'h0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b1, 8'h13, 32'h0, 1'b0, 2'b00, 32'hFFFFFFEF));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 8'h13, 32'h0, 1'b0, 2'b00, 32'h000000EF));
      vecs.push_back(mk(1'b0, 2'b01, 1'b1, 8'h12, 32'h0, 1'b0, 2'b00, 32'hFFFFBEEF));
      vecs.push_back(mk(1'b0, 2'b01, 1'b0, 8'h10, 32'h0, 1'b0, 2'b00, 32'h0000DEAD));
      vecs.push_back(mk(1'b1, 2'b01, 1'b0, 8'h20, 32'h00001234, 1'b0, 2'b00, 32'h0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b1, 8'h20, 32'h0, 1'b0, 2'b00, 32'h00001234));
      vecs.push_back(mk(1'b0, 2'b01, 1'b0, 8'h11, 32'h0, 1'b1, 2'b01, 32'h0));
      vecs.push_back(mk(1'b0, 2'b11, 1'b0, 8'h00, 32'h0, 1'b1, 2'b10, 32'h0));
      vecs.push_back(mk(1'b1, 2'b11, 1'b0, 8'h03, 32'h12345678, 1'b1, 2'b10, 32'h0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 8'hFE, 32'h0, 1'b1, 2'b01, 32'h0));
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 8'h22, 32'h55555555, 1'b1, 2'b01, 32'h0));
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 8'h7C, 32'h01020304, 1'b0, 2'b00, 32'h0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b1, 8'h7F, 32'h0, 1'b0, 2'b00, 32'h00000004));
`ifdef MEM_BOUNDS_CHECK_EN
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 8'h80, 32'hCAFEF00D, 1'b1, 2'b11, 32'h0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 8'h80, 32'h0, 1'b1, 2'b11, 32'h0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 8'hFF, 32'h0, 1'b1, 2'b11, 32'h0));
`else
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 8'h80, 32'hCAFEF00D, 1'b0, 2'b00, 32'h0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 8'h80, 32'h0, 1'b0, 2'b00, 32'hCAFEF00D));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 8'h83, 32'h0, 1'b0, 2'b00, 32'h0000000D));
`endif

      tick();
      tick();
      chk("rst req_ready", 32'(req_ready), 32'd1);
      chk("rst resp_valid", 32'(resp_valid), 32'd0);
      chk("rst resp_trap", 32'(resp_trap), 32'd0);
      chk("rst resp_cause", 32'(resp_cause), 32'd0);
      chk("rst resp_rdata", resp_rdata, 32'h0);
      chk("rst ram_en", 32'(ram_en), 32'd0);
      chk("rst ram_addr", 32'(ram_addr), 32'd0);
      chk("rst ram_wdata", ram_wdata, 32'h0);
      rst_n = 1'b1;
      tick();

      foreach (vecs[k]) run_vec(k, vecs[k]);

      // Backpressure: response must hold for 5 stalled cycles.
      resp_ready = 1'b0;
      drive_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
      tick();
      req_valid = 1'b0;
      for (int c = 0; c < 8 && !resp_valid; c++) tick();
      chk("bp valid", 32'(resp_valid), 32'd1);
      hold_rdata = resp_rdata;
      chk("bp rdata", hold_rdata, 32'hDEADBEEF);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("bp%0d valid", c), 32'(resp_valid), 32'd1);
         chk($sformatf("bp%0d rdata", c), resp_rdata, 32'hDEADBEEF);
         chk($sformatf("bp%0d trap", c), 32'(resp_trap), 32'd0);
         chk($sformatf("bp%0d req_ready", c), 32'(req_ready), 32'd0);
         chk($sformatf("bp%0d ram_en", c), 32'(ram_en), 32'd0);
      end
      resp_ready = 1'b1;
      tick();
      chk("bp release", 32'(resp_valid), 32'd0);
      chk("bp idle", 32'(req_ready), 32'd1);

      // Throughput: valid held high, ACCESS cycles must be 3 apart.
      i1 = -1; i2 = -1;
      drive_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
      for (cyc = 0; cyc < 20 && i2 < 0; cyc++) begin
         tick();
         if (ram_en) begin
            if (i1 < 0) i1 = cyc;
            else i2 = cyc;
         end
      end
      req_valid = 1'b0;
      chk("tput gap", 32'(i2 - i1), 32'd3);
      for (int c = 0; c < 10 && !(req_ready && !resp_valid); c++) tick();
      chk("tput drain", 32'(req_ready), 32'd1);

      // Reset in ACCESS abandons the request; no response may appear.
      drive_req(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
      tick();
      req_valid = 1'b0;
      chk("rstacc in_access", 32'(ram_en), 32'd1);
      rst_n = 1'b0;
      tick();
      chk("rstacc ram_en", 32'(ram_en), 32'd0);
      chk("rstacc resp_valid", 32'(resp_valid), 32'd0);
      chk("rstacc idle", 32'(req_ready), 32'd1);
      chk("rstacc rdata", resp_rdata, 32'h0);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (resp_valid || ram_en) seen = 1'b1;
      end
      chk("rstacc no_resp", 32'(seen), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
